uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter between N_REQ byte producers (e.g. switch
//  sampler, status reporter, RX loopback echo). Round-robin grant, one-byte
//  valid/ready handshake per requester, drives the transmitter's data-valid
//  strobe and byte, waits for frame completion, then enforces an inter-frame gap.
//  Sits between the producers and the transmitter inside uart_top.
// PARAMETERS
//  N_REQ         4      number of requesters (2..8)
//  DATA_WIDTH    8      byte width, matches the transmitter's byte width
//  GAP_CLKS      16     idle clocks inserted after each frame (0 = no gap)
//  TIMEOUT_CLKS  13020  max clocks from tx_dv to tx_done (about 12 bit times at 1085 clk/bit)
// PORTS
//  sysclk       in   1                 system clock (125 MHz)
//  rst          in   1                 synchronous, active-high reset
//  req_valid    in   N_REQ             per-requester byte available
//  req_data     in   N_REQ*DATA_WIDTH  byte k in bits [k*DATA_WIDTH +: DATA_WIDTH]
//  req_ready    out  N_REQ             one-hot, 1-cycle pulse: byte k accepted
//  tx_dv        out  1                 1-cycle start strobe to transmitter
//  tx_byte      out  DATA_WIDTH        byte to transmitter, held stable until next grant
//  tx_active    in   1                 transmitter busy
//  tx_done      in   1                 transmitter 1-cycle frame-complete pulse
//  grant_id     out  $clog2(N_REQ)     index of the last granted requester
//  busy         out  1                 high in any state except IDLE
//  timeout_err  out  1                 sticky: a frame never completed
// BEHAVIOUR
//  - One clock: sysclk. Reset is synchronous and active-high.
//  - Reset: state=IDLE; req_ready=0, tx_dv=0, tx_byte=0, grant_id=0, busy=0,
//    timeout_err=0. The round-robin pointer is set so requester 0 has top
//    priority.
//  - Reset mid-frame aborts immediately. No done is awaited. The transmitter
//    has its own reset.
//  - FSM states: IDLE -> ISSUE -> WAIT -> GAP -> IDLE.
//  - IDLE: if tx_active=0 and any req_valid=1, choose k.
//    - k is the first valid index searched cyclically from grant_id+1.
//    - After reset, the search starts at 0.
//    - On the edge: tx_byte <= req_data[k], grant_id <= k, state <= ISSUE.
//  - ISSUE (exactly 1 cycle): tx_dv=1 and req_ready[k]=1 (both registered).
//    - The requester must hold valid and data stable until it sees req_ready.
//    - It may drop valid or present a new byte on the following edge.
//    - Next state: WAIT. Timeout counter is cleared.
//  - WAIT: the timeout counter increments each cycle.
//    - tx_done=1 -> GAP.
//    - Counter reaches TIMEOUT_CLKS-1 with no done -> timeout_err <= 1, then GAP.
//    - tx_done is ignored outside WAIT.
//  - GAP: stays for exactly GAP_CLKS cycles, then IDLE.
//    - GAP_CLKS=0: WAIT goes directly to IDLE.
//  - Latency:
//    - req_valid seen in IDLE at cycle T -> tx_dv and req_ready at T+1.
//    - tx_done at cycle D -> earliest next tx_dv at D+GAP_CLKS+2.
//  - Fairness:
//    - The granted requester has lowest priority in the next arbitration.
//    - With all N_REQ continuously valid, grants rotate k, k+1, ..., wrapping
//      N_REQ-1 -> 0.
//  - Simultaneous events:
//    - tx_active=1 in IDLE blocks any grant.
//    - A new req_valid arriving during ISSUE/WAIT/GAP waits for IDLE.
//    - tx_done and timeout in the same cycle count as done; no error is set.
//  - Output rules:
//    - At most one bit of req_ready is high, and only in the same cycle as tx_dv.
//    - tx_byte does not change outside the IDLE->ISSUE edge.
//  - Counters are sized by $clog2 of their parameter plus 1 and saturate;
//    they never wrap.
// TESTING
//  1 Reset: assert rst 3 cycles -> all outputs 0, state IDLE; pulse rst during
//    WAIT -> tx_dv/req_ready/busy 0 on the next cycle, no grant follows.
//  2 Single request: req_valid=4'b0100, data2=8'h0B -> next cycle tx_dv=1,
//    req_ready=4'b0100, tx_byte=8'h0B, grant_id=2; tx_done 50 cycles later ->
//    busy low after 16 GAP cycles.
//  3 Round robin: all 4 valid, tx_done 10 cycles after each tx_dv ->
//    grant_id sequence 0,1,2,3,0; spacing between tx_dv pulses = 10+16+2 cycles.
//  4 Blocked start: tx_active=1 with req_valid=4'b0001 -> no tx_dv; drop
//    tx_active -> tx_dv one cycle after IDLE sees tx_active=0.
//  5 Timeout: grant, never pulse tx_done -> timeout_err=1 exactly TIMEOUT_CLKS
//    cycles after the WAIT entry; after the gap, the next grant proceeds;
//    timeout_err stays 1 until rst.
//  6 Done/timeout collision: pulse tx_done on the final timeout cycle ->
//    timeout_err stays 0; GAP_CLKS=0 build -> next tx_dv at D+2.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between N_REQ byte producers.
// Issues a one-cycle start strobe, waits for frame completion or timeout, then holds an idle gap.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int GAP_CLKS     = 16,
    parameter int TIMEOUT_CLKS = 13020
) (
    input  logic                          sysclk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          tx_dv,
    output logic [DATA_WIDTH-1:0]         tx_byte,
    input  logic                          tx_active,
    input  logic                          tx_done,
    output logic [$clog2(N_REQ)-1:0]      grant_id,
    output logic                          busy,
    output logic                          timeout_err
);
    // state  | meaning
    // IDLE   | waiting for a valid request while the transmitter is idle
    // ISSUE  | one cycle: tx_dv and req_ready pulse for the granted requester
    // WAIT   | frame in flight, timeout counter running
    // GAP    | GAP_CLKS idle cycles before the next arbitration

    localparam int ID_W  = $clog2(N_REQ);
    localparam int TO_W  = $clog2(TIMEOUT_CLKS) + 1;
    localparam int GAP_W = $clog2(GAP_CLKS) + 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

    state_t                  state, state_nxt;
    logic [ID_W-1:0]         ptr;
    logic [ID_W-1:0]         pick;
    logic [ID_W-1:0]         scan_idx;
    logic                    any_valid;
    logic [N_REQ-1:0]        pick_onehot;
    logic [DATA_WIDTH-1:0]   pick_byte;
    logic [TO_W-1:0]         to_cnt;
    logic [GAP_W-1:0]        gap_cnt;
    logic                    to_hit;
    logic                    grant;

    // ptr is the first index searched; it sits one past the last grant so that requester is last
    always_comb begin
        any_valid = 1'b0;
        pick      = '0;
        scan_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_idx = ID_W'((int'(ptr) + i) % N_REQ);
            if (!any_valid && req_valid[scan_idx]) begin
                any_valid = 1'b1;
                pick      = scan_idx;
            end
        end
    end

    always_comb begin
        pick_onehot = '0;
        pick_byte   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == pick) begin
                pick_onehot[i] = 1'b1;
                pick_byte      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign to_hit = (to_cnt >= TO_LAST);
    assign grant  = (state == S_IDLE) && (state_nxt == S_ISSUE);
    assign busy   = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!tx_active && any_valid) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (tx_done || to_hit) state_nxt = (GAP_CLKS == 0) ? S_IDLE : S_GAP;
            S_GAP:   if (gap_cnt == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= '0;
            grant_id    <= '0;
            tx_byte     <= '0;
            tx_dv       <= 1'b0;
            req_ready   <= '0;
            to_cnt      <= '0;
            gap_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            tx_dv     <= 1'b0;
            req_ready <= '0;
            if (grant) begin
                tx_byte   <= pick_byte;
                grant_id  <= pick;
                ptr       <= (pick == ID_W'(N_REQ - 1)) ? '0 : pick + ID_W'(1);
                tx_dv     <= 1'b1;
                req_ready <= pick_onehot;
            end
            if (state == S_ISSUE) begin
                to_cnt <= '0;
            end else if (state == S_WAIT && to_cnt != '1) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            // a done arriving on the last timeout cycle wins, so no error is flagged
            if (state == S_WAIT && to_hit && !tx_done) timeout_err <= 1'b1;
            if (state == S_WAIT) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == S_GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: default build plus a GAP_CLKS=0 build with a short timeout.
module tb_uart_tx_arbiter;
    localparam int TO0 = 13020;
    localparam int TO1 = 64;

    logic        sysclk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic        tx_active;
    logic        tx_done0, tx_done1;

    logic [3:0]  ready0, ready1;
    logic        dv0, dv1;
    logic [7:0]  byte0, byte1;
    logic [1:0]  gid0, gid1;
    logic        busy0, busy1;
    logic        terr0, terr1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] exp_byte [4];

    always #5 sysclk = ~sysclk;

    uart_tx_arbiter dut0 (
        .sysclk(sysclk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(ready0), .tx_dv(dv0), .tx_byte(byte0), .tx_active(tx_active),
        .tx_done(tx_done0), .grant_id(gid0), .busy(busy0), .timeout_err(terr0)
    );

    uart_tx_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .GAP_CLKS(0), .TIMEOUT_CLKS(TO1)) dut1 (
        .sysclk(sysclk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(ready1), .tx_dv(dv1), .tx_byte(byte1), .tx_active(tx_active),
        .tx_done(tx_done1), .grant_id(gid1), .busy(busy1), .timeout_err(terr1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
        cyc++;
    endtask

    task automatic wait_dv(input bit sel, input string tag);
        int n = 0;
        while (((sel ? dv1 : dv0) !== 1'b1) && n < 2000) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(sel ? dv1 : dv0), 32'd1);
    endtask

    task automatic wait_idle0(input string tag);
        int n = 0;
        while (busy0 !== 1'b0 && n < 20000) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(busy0), 32'd0);
    endtask

    initial begin
        int  last_dv;
        bit  seen;
        exp_byte[0] = 8'hA1;
        exp_byte[1] = 8'h5A;
        exp_byte[2] = 8'h0B;
        exp_byte[3] = 8'hD3;
        req_data  = {8'hD3, 8'h0B, 8'h5A, 8'hA1};
        rst       = 1'b1;
        req_valid = '0;
        tx_active = 1'b0;
        tx_done0  = 1'b0;
        tx_done1  = 1'b0;

        // reset values
        repeat (3) tick();
        check_eq("rst_tx_dv", 32'(dv0), 0);
        check_eq("rst_req_ready", 32'(ready0), 0);
        check_eq("rst_tx_byte", 32'(byte0), 0);
        check_eq("rst_grant_id", 32'(gid0), 0);
        check_eq("rst_busy", 32'(busy0), 0);
        check_eq("rst_timeout_err", 32'(terr0), 0);
        rst = 1'b0;
        tick();

        // single request from requester 2
        req_valid = 4'b0100;
        tick();
        check_eq("single_tx_dv", 32'(dv0), 1);
        check_eq("single_req_ready", 32'(ready0), 32'b0100);
        check_eq("single_tx_byte", 32'(byte0), 32'h0B);
        check_eq("single_grant_id", 32'(gid0), 2);
        req_valid = '0;
        repeat (49) tick();
        check_eq("single_dv_one_cycle", 32'(dv0), 0);
        tx_done0 = 1'b1;
        tick();
        tx_done0 = 1'b0;
        repeat (15) tick();
        check_eq("single_busy_last_gap", 32'(busy0), 1);
        tick();
        check_eq("single_busy_after_gap", 32'(busy0), 0);
        check_eq("single_byte_held", 32'(byte0), 32'h0B);

        // reset while a frame is in WAIT
        req_valid = 4'b0001;
        tick();
        check_eq("midrst_grant_id", 32'(gid0), 0);
        req_valid = '0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_tx_dv", 32'(dv0), 0);
        check_eq("midrst_req_ready", 32'(ready0), 0);
        check_eq("midrst_busy", 32'(busy0), 0);
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (dv0 !== 1'b0 || busy0 !== 1'b0) seen = 1'b1;
        end
        check_eq("midrst_no_grant", 32'(seen), 0);

        // round robin with all four valid
        req_valid = 4'b1111;
        last_dv = 0;
        for (int g = 0; g < 5; g++) begin
            wait_dv(1'b0, "rr_dv_seen");
            check_eq("rr_grant_id", 32'(gid0), 32'(g % 4));
            check_eq("rr_req_ready", 32'(ready0), 32'(1 << (g % 4)));
            check_eq("rr_tx_byte", 32'(byte0), 32'(exp_byte[g % 4]));
            if (g > 0) check_eq("rr_spacing", 32'(cyc - last_dv), 32'd28);
            last_dv = cyc;
            if (g == 4) req_valid = '0;
            repeat (10) tick();
            tx_done0 = 1'b1;
            tick();
            tx_done0 = 1'b0;
        end
        wait_idle0("rr_idle");

        // blocked start while the transmitter is active
        tx_active = 1'b1;
        req_valid = 4'b0001;
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (dv0 !== 1'b0) seen = 1'b1;
        end
        check_eq("blocked_no_dv", 32'(seen), 0);
        tx_active = 1'b0;
        tick();
        check_eq("blocked_dv_after_release", 32'(dv0), 1);
        check_eq("blocked_grant_id", 32'(gid0), 0);
        req_valid = '0;

        // timeout: no tx_done for this frame
        tick();
        repeat (TO0 - 1) tick();
        check_eq("timeout_not_early", 32'(terr0), 0);
        tick();
        check_eq("timeout_set", 32'(terr0), 1);
        check_eq("timeout_busy_gap", 32'(busy0), 1);
        wait_idle0("timeout_idle");
        req_valid = 4'b0010;
        wait_dv(1'b0, "timeout_next_dv");
        check_eq("timeout_next_grant", 32'(gid0), 1);
        req_valid = '0;
        repeat (5) tick();
        tx_done0 = 1'b1;
        tick();
        tx_done0 = 1'b0;
        check_eq("timeout_sticky", 32'(terr0), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("timeout_cleared_by_rst", 32'(terr0), 0);

        // done/timeout collision on the GAP_CLKS=0 build
        req_valid = 4'b0100;
        wait_dv(1'b1, "coll_dv_seen");
        check_eq("coll_grant_id", 32'(gid1), 2);
        check_eq("coll_tx_byte", 32'(byte1), 32'h0B);
        req_valid = '0;
        tick();
        repeat (TO1 - 1) tick();
        tx_done1  = 1'b1;
        req_valid = 4'b0001;
        tick();
        tx_done1 = 1'b0;
        check_eq("coll_no_err", 32'(terr1), 0);
        check_eq("coll_idle_d1", 32'(busy1), 0);
        check_eq("coll_no_dv_d1", 32'(dv1), 0);
        tick();
        check_eq("coll_dv_d2", 32'(dv1), 1);
        check_eq("coll_grant_d2", 32'(gid1), 0);
        check_eq("coll_ready_d2", 32'(ready1), 32'b0001);
        req_valid = '0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
